// File: rtl/serial_add_ctrl_if.sv
// Operand and result handshake bundle for the bit-serial adder sequencer.
`timescale 1ns/1ps

interface serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    // Operand side: producer -> adder
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;

    // Result side: adder -> consumer
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // Status
    logic             busy;

    // Environment side: drives operands, accepts results
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    // Adder side
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell walks LSB-first across
// WIDTH bits, with valid/ready handshakes on operand capture and result release.
`timescale 1ns/1ps

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_add_ctrl_if.slave      bus
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CNT_W-1:0] count;

    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic             fa_s_c;
    logic             fa_co_c;

    // The single shared full-adder cell, fed from the operand LSBs and the carry flop
    always_comb begin
        fa_s_c  = a_sr[0] ^ b_sr[0] ^ carry;
        fa_co_c = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    end

    // Sequencer and datapath; handshake/status outputs are flops updated with the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            a_sr        <= '0;
            b_sr        <= '0;
            sum_sr      <= '0;
            carry       <= 1'b0;
            count       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_sr       <= bus.a;
                        b_sr       <= bus.b;
                        carry      <= bus.cin;
                        count      <= '0;
                        state      <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end

                RUN: begin
                    sum_sr <= {fa_s_c, sum_sr[WIDTH-1:1]};
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= fa_co_c;
                    // Counter stops at the last bit; it is reloaded on the next accept
                    if (count == LAST_BIT) begin
                        state       <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end

                DONE: begin
                    // Only the result handshake leaves DONE; sum and carry hold meanwhile
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end

                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.sum       = sum_sr;
    assign bus.cout      = carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=16.
`timescale 1ns/1ps

module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(8))  i8 ();
    serial_add_ctrl_if #(.WIDTH(16)) i16 ();

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (i8)
    );

    serial_add_ctrl #(.WIDTH(16)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (i16)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [8:0]  sb8  [$];
    logic [16:0] sb16 [$];

    task automatic test_reset();
        rst = 1'b1;
        i8.in_valid = 1'b0;  i8.out_ready = 1'b0;  i8.a = '0;  i8.b = '0;  i8.cin = 1'b0;
        i16.in_valid = 1'b0; i16.out_ready = 1'b0; i16.a = '0; i16.b = '0; i16.cin = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (i8.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b, expected 1", i8.in_ready); end
        vectors++;
        if (i8.out_valid !== 1'b0 || i8.busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_flags: out_valid=%b busy=%b, expected 0 0", i8.out_valid, i8.busy);
        end
        vectors++;
        if ({i8.cout, i8.sum} !== 9'h000) begin miscompares++; $display("FAIL reset_result: got %h, expected 000", {i8.cout, i8.sum}); end
        vectors++;
        if (i16.in_ready !== 1'b1 || {i16.cout, i16.sum} !== 17'h0) begin
            miscompares++; $display("FAIL reset_w16: in_ready=%b result=%h, expected 1 00000", i16.in_ready, {i16.cout, i16.sum});
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (i8.in_ready !== 1'b1 || i8.busy !== 1'b0) begin
            miscompares++; $display("FAIL post_reset_idle: in_ready=%b busy=%b, expected 1 0", i8.in_ready, i8.busy);
        end
    endtask

    task automatic test_latency();
        int n;
        i8.a = 8'h3C; i8.b = 8'h5A; i8.cin = 1'b0; i8.in_valid = 1'b1; i8.out_ready = 1'b0;
        @(negedge clk);
        i8.in_valid = 1'b0;
        vectors++;
        if (i8.busy !== 1'b1 || i8.in_ready !== 1'b0) begin
            miscompares++; $display("FAIL accept: busy=%b in_ready=%b, expected 1 0", i8.busy, i8.in_ready);
        end
        n = 0;
        while (i8.out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n != 8) begin miscompares++; $display("FAIL latency: got %0d edges, expected 8", n); end
        vectors++;
        if ({i8.cout, i8.sum} !== 9'h096) begin miscompares++; $display("FAIL sum_3c_5a: got %h, expected 096", {i8.cout, i8.sum}); end
        vectors++;
        if (i8.busy !== 1'b0 || i8.in_ready !== 1'b0) begin
            miscompares++; $display("FAIL done_flags: busy=%b in_ready=%b, expected 0 0", i8.busy, i8.in_ready);
        end
        i8.out_ready = 1'b1;
        @(negedge clk);
        i8.out_ready = 1'b0;
        vectors++;
        if (i8.out_valid !== 1'b0 || i8.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL release: out_valid=%b in_ready=%b, expected 0 1", i8.out_valid, i8.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp_v [2];
        logic [8:0] exp;
        int acc_t [2];
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        bit fin, fout;
        exp_v[0] = 9'h100;
        exp_v[1] = 9'h1FF;
        acc_t[0] = 0;
        acc_t[1] = 0;
        sb8.delete();
        i8.a = 8'hFF; i8.b = 8'h01; i8.cin = 1'b0; i8.in_valid = 1'b1; i8.out_ready = 1'b1;
        while (got < 2 && cyc < 100) begin
            fin  = i8.in_valid && i8.in_ready;
            fout = i8.out_valid && i8.out_ready;
            if (fout) begin
                vectors++;
                if (sb8.size() == 0) begin
                    miscompares++; $display("FAIL b2b_extra: unexpected result %h", {i8.cout, i8.sum});
                end else begin
                    exp = sb8.pop_front();
                    if ({i8.cout, i8.sum} !== exp) begin
                        miscompares++; $display("FAIL b2b_result: got %h, expected %h", {i8.cout, i8.sum}, exp);
                    end
                end
                got++;
            end
            if (fin) begin
                sb8.push_back(exp_v[sent]);
                acc_t[sent] = cyc;
                sent++;
            end
            @(negedge clk);
            cyc++;
            if (fin) begin
                if (sent == 1) begin
                    i8.a = 8'hFF; i8.b = 8'hFF; i8.cin = 1'b1;
                end else begin
                    i8.in_valid = 1'b0;
                end
            end
        end
        i8.in_valid = 1'b0;
        i8.out_ready = 1'b0;
        vectors++;
        if (got != 2) begin miscompares++; $display("FAIL b2b_count: got %0d results, expected 2", got); end
        vectors++;
        if (acc_t[1] - acc_t[0] != 10) begin
            miscompares++; $display("FAIL b2b_interval: got %0d cycles, expected 10", acc_t[1] - acc_t[0]);
        end
    endtask

    task automatic test_backpressure();
        int n;
        int bad = 0;
        i8.a = 8'h22; i8.b = 8'h33; i8.cin = 1'b1; i8.in_valid = 1'b1; i8.out_ready = 1'b0;
        @(negedge clk);
        i8.in_valid = 1'b0;
        n = 0;
        while (i8.out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (i8.out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_done: out_valid=%b, expected 1", i8.out_valid); end
        // Offer a second operand while the result is stalled
        i8.a = 8'h11; i8.b = 8'h01; i8.cin = 1'b0; i8.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if ({i8.cout, i8.sum} !== 9'h056 || i8.in_ready !== 1'b0 || i8.busy !== 1'b0 || i8.out_valid !== 1'b1) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL bp_hold: %0d bad cycles, last result=%h in_ready=%b busy=%b out_valid=%b, expected 056 0 0 1",
                     bad, {i8.cout, i8.sum}, i8.in_ready, i8.busy, i8.out_valid);
        end
        i8.out_ready = 1'b1;
        @(negedge clk);
        i8.out_ready = 1'b0;
        vectors++;
        if (i8.busy !== 1'b0 || i8.in_ready !== 1'b1 || i8.out_valid !== 1'b0) begin
            miscompares++; $display("FAIL bp_no_early_capture: busy=%b in_ready=%b out_valid=%b, expected 0 1 0",
                                    i8.busy, i8.in_ready, i8.out_valid);
        end
        @(negedge clk);
        i8.in_valid = 1'b0;
        vectors++;
        if (i8.busy !== 1'b1) begin miscompares++; $display("FAIL bp_second_accept: busy=%b, expected 1", i8.busy); end
        n = 0;
        while (i8.out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if ({i8.cout, i8.sum} !== 9'h012) begin miscompares++; $display("FAIL bp_second_sum: got %h, expected 012", {i8.cout, i8.sum}); end
        i8.out_ready = 1'b1;
        @(negedge clk);
        i8.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        bit seen_ov = 1'b0;
        i8.a = 8'h0F; i8.b = 8'h01; i8.cin = 1'b0; i8.in_valid = 1'b1; i8.out_ready = 1'b1;
        @(negedge clk);
        i8.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (i8.busy !== 1'b1) begin miscompares++; $display("FAIL rst_mid_running: busy=%b, expected 1", i8.busy); end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (i8.out_valid !== 1'b0) seen_ov = 1'b1;
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (i8.in_ready !== 1'b1 || {i8.cout, i8.sum} !== 9'h000 || i8.busy !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid_state: in_ready=%b result=%h busy=%b, expected 1 000 0",
                                    i8.in_ready, {i8.cout, i8.sum}, i8.busy);
        end
        repeat (12) begin
            @(negedge clk);
            if (i8.out_valid !== 1'b0) seen_ov = 1'b1;
        end
        vectors++;
        if (seen_ov) begin miscompares++; $display("FAIL rst_mid_out_valid: got 1, expected 0"); end
        i8.a = 8'h80; i8.b = 8'h80; i8.cin = 1'b0; i8.in_valid = 1'b1; i8.out_ready = 1'b0;
        @(negedge clk);
        i8.in_valid = 1'b0;
        n = 0;
        while (i8.out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (i8.out_valid !== 1'b1 || {i8.cout, i8.sum} !== 9'h100) begin
            miscompares++; $display("FAIL rst_mid_next_op: out_valid=%b result=%h, expected 1 100", i8.out_valid, {i8.cout, i8.sum});
        end
        i8.out_ready = 1'b1;
        @(negedge clk);
        i8.out_ready = 1'b0;
    endtask

    task automatic test_random8();
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        bit fin, fout;
        logic [8:0] exp;
        sb8.delete();
        i8.in_valid = 1'b0;
        i8.out_ready = 1'b0;
        while (got < 1000 && cyc < 40000) begin
            fin  = i8.in_valid && i8.in_ready;
            fout = i8.out_valid && i8.out_ready;
            if (fout) begin
                vectors++;
                if (sb8.size() == 0) begin
                    miscompares++; $display("FAIL rand8_extra: unexpected result %h", {i8.cout, i8.sum});
                end else begin
                    exp = sb8.pop_front();
                    if ({i8.cout, i8.sum} !== exp) begin
                        miscompares++; $display("FAIL rand8_result: got %h, expected %h", {i8.cout, i8.sum}, exp);
                    end
                end
                got++;
            end
            if (fin) begin
                sb8.push_back(9'(i8.a) + 9'(i8.b) + 9'(i8.cin));
                sent++;
            end
            @(negedge clk);
            cyc++;
            if (fin || !i8.in_valid) begin
                if (sent < 1000 && $urandom_range(0, 3) != 0) begin
                    i8.a = 8'($urandom); i8.b = 8'($urandom); i8.cin = 1'($urandom); i8.in_valid = 1'b1;
                end else begin
                    i8.in_valid = 1'b0;
                end
            end
            i8.out_ready = ($urandom_range(0, 2) != 0);
        end
        i8.in_valid = 1'b0;
        i8.out_ready = 1'b0;
        vectors++;
        if (got != 1000 || sb8.size() != 0) begin
            miscompares++; $display("FAIL rand8_count: got %0d results, %0d pending, expected 1000 0", got, sb8.size());
        end
    endtask

    task automatic test_random16();
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        bit fin, fout;
        logic [16:0] exp;
        sb16.delete();
        i16.in_valid = 1'b0;
        i16.out_ready = 1'b0;
        while (got < 1000 && cyc < 40000) begin
            fin  = i16.in_valid && i16.in_ready;
            fout = i16.out_valid && i16.out_ready;
            if (fout) begin
                vectors++;
                if (sb16.size() == 0) begin
                    miscompares++; $display("FAIL rand16_extra: unexpected result %h", {i16.cout, i16.sum});
                end else begin
                    exp = sb16.pop_front();
                    if ({i16.cout, i16.sum} !== exp) begin
                        miscompares++; $display("FAIL rand16_result: got %h, expected %h", {i16.cout, i16.sum}, exp);
                    end
                end
                got++;
            end
            if (fin) begin
                sb16.push_back(17'(i16.a) + 17'(i16.b) + 17'(i16.cin));
                sent++;
            end
            @(negedge clk);
            cyc++;
            if (fin || !i16.in_valid) begin
                if (sent < 1000 && $urandom_range(0, 3) != 0) begin
                    i16.a = 16'($urandom); i16.b = 16'($urandom); i16.cin = 1'($urandom); i16.in_valid = 1'b1;
                end else begin
                    i16.in_valid = 1'b0;
                end
            end
            i16.out_ready = ($urandom_range(0, 2) != 0);
        end
        i16.in_valid = 1'b0;
        i16.out_ready = 1'b0;
        vectors++;
        if (got != 1000 || sb16.size() != 0) begin
            miscompares++; $display("FAIL rand16_count: got %0d results, %0d pending, expected 1000 0", got, sb16.size());
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random8();
        test_random16();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder sequencer. The block time-multiplexes one combinational full-adder cell across all bit positions of a WIDTH-bit addition. It captures two operands and a carry-in through a valid/ready handshake, then steps LSB-first through one bit per clock with a registered carry. It presents the sum and carry-out through a second valid/ready handshake. It sits between an operand producer and a result consumer wherever area matters more than latency.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 2..64.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  operands a, b, cin are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  sum/cout are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result bits, a+b+cin mod 2^WIDTH.
- cout  output  1  carry-out of bit WIDTH-1.
- busy  output  1  high in RUN state.

## Operation
- Datapath: A and B shift registers (WIDTH bits each); sum shift register (WIDTH bits); carry flop; bit counter of clog2(WIDTH) bits.
- The datapath contains exactly one full-adder cell:
  - s = a0 ^ b0 ^ c
  - co = majority(a0, b0, c)
  - a0 and b0 are the LSBs of the A and B shift registers.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: A <= a, B <= b, carry <= cin, count <= 0. Go to RUN.
  - Otherwise hold.
- RUN (each edge):
  - sum <= {s, sum[WIDTH-1:1]}; A, B shift right by 1; carry <= co; count <= count+1.
  - The edge with count == WIDTH-1 additionally transitions to DONE. cout is the final carry.
- DONE:
  - out_valid = 1; sum and cout are held stable.
  - On out_valid & out_ready: go to IDLE.
- in_ready is high only in IDLE. in_valid, a, b and cin are ignored in RUN and DONE.
- busy = (state == RUN); out_valid = (state == DONE). Both decode from registered state and are glitch-free.
- cout is the carry flop, visible in DONE.
- Only the result handshake deasserts DONE. Input activity has no effect on DONE.
- Arithmetic: {cout, sum} = a + b + cin, exact, WIDTH+1 bits. No overflow flag.

## Timing
- Reset values:
  - state = IDLE, so in_ready = 1.
  - out_valid = 0, busy = 0.
  - sum = 0, cout = 0.
  - A, B, count = 0.
- Latency: the accept edge is E0. The block is in RUN for edges E1..EWIDTH. out_valid rises after edge EWIDTH, so the result is valid WIDTH cycles after acceptance.
- Minimum initiation interval is WIDTH+2 cycles: 1 accept + WIDTH run + 1 DONE with out_ready already high. in_ready rises the cycle after the result handshake.
- Backpressure: out_ready low holds DONE indefinitely. sum and cout must not change during the hold.
- Reset mid-operation (RUN or DONE) abandons the operation immediately.
  - No out_valid is produced for the abandoned operation.
  - After rst deasserts, the block is in IDLE with reset values.
- Wrap-around: count never exceeds WIDTH-1. It is reloaded on every accept.

## Test plan
- WIDTH=8; a=0x3C, b=0x5A, cin=0 → out_valid rises exactly 8 edges after accept; sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1. Issue them back-to-back with the interval measured as 10 cycles.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with a=0x11. Require:
  - sum and cout stable throughout;
  - in_ready=0 and busy=0;
  - the second operand not captured until after the result handshake.
- Assert rst at the 3rd RUN edge. Require:
  - out_valid stays 0;
  - in_ready=1 and sum=0 after reset;
  - the next op, 0x80+0x80 cin=0, gives sum=0x00, cout=1.
- Random: 1000 ops each at WIDTH=8 and WIDTH=16, with random in_valid/out_ready gaps. Compare {cout, sum} against a+b+cin; no lost or duplicated results.
